tx_fifo_wr_arb: RTL and testbench
=================================

// Module: tx_fifo_wr_arb
// PURPOSE
//  Frame-granular round-robin arbiter sharing the 1024x256 TX data FIFO write port between two host channels.
//  Admits a frame only when the FIFO reports room for the whole frame plus headroom, so frames never interleave.
//  Streams the granted channel's words into the FIFO through one register stage.
//  Sits on the FIFO write-clock side, between the host DMA channels and the TX FIFO.
// PARAMETERS
//  WIDTH     256   data word width (bits)
//  DEPTH     1024  FIFO depth (words)
//  PTR       10    FIFO pointer width; wrusedw is PTR+1 bits
//  LEN_W     8     frame length field width (words, 0..2^LEN_W-1)
//  HEADROOM  4     extra free words required beyond frame length (covers wrusedw lag)
// PORTS
//  clk          in   1        FIFO write clock
//  reset_       in   1        asynchronous, active-low reset
//  ch0_req      in   1        ch0 has a frame pending; held until ch0_done
//  ch0_len      in   LEN_W    ch0 frame length in words, stable while ch0_req=1
//  ch0_valid    in   1        ch0 data word valid (only honoured while ch0_gnt=1)
//  ch0_data     in   WIDTH    ch0 data word
//  ch0_gnt      out  1        ch0 owns the FIFO write port
//  ch0_done     out  1        1-cycle pulse: ch0 frame fully accepted
//  ch1_*        --   --       identical set for channel 1
//  fifo_wrusedw in   PTR+1    FIFO words in use
//  fifo_wrfull  in   1        FIFO full
//  fifo_wrreq   out  1        FIFO write request (registered)
//  fifo_data    out  WIDTH    FIFO write data (registered)
//  busy         out  1        state != IDLE
//  len_err      out  1        sticky: zero-length frame seen
//  ovf_err      out  1        sticky: write attempted while fifo_wrfull=1
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr_last=1 (ch0 preferred first); reset mid-frame abandons the frame, no done.
//  FSM IDLE -> SEL -> WAIT_SPACE -> XFER -> IDLE.
//  IDLE: any req -> SEL. SEL: winner = sole requester, else channel != rr_last; latch winner and len.
//  WAIT_SPACE: free = DEPTH - fifo_wrusedw (PTR+1 bits); need = len + HEADROOM (zero-extended, no wrap).
//   free >= need -> XFER, gnt asserted next cycle. Strict head-of-line: other channel is not bypassed.
//   len==0 -> set len_err, pulse winner done, rr_last=winner, -> IDLE; no FIFO write.
//  XFER: gnt=1 for winner only; each cycle chX_valid=1 is one word accepted (bubbles allowed).
//   Word counter (LEN_W bits) increments per accepted word; on word len-1: done pulse same cycle,
//   gnt drops next cycle, rr_last=winner, -> IDLE. Min frame gap 3 cycles (IDLE,SEL,WAIT_SPACE).
//  Datapath: fifo_wrreq/fifo_data = registered (gnt & valid, data); latency 1 cycle; never the loser's data.
//  fifo_wrfull=1 on a registered write: write still issued, ovf_err set (sticky until reset).
//  chX_req dropping mid-XFER is ignored; the frame completes on word count only.
//  Valid from a non-granted channel is ignored, no side effects.
// CONFIGURATION
//  TXARB_STATS_EN defined: adds outputs ch0_frm_cnt, ch1_frm_cnt [31:0], +1 on each done pulse
//   (incl. zero-length), wrap at 2^32, reset 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  Reset, ch0_req len=4, valid every cycle, wrusedw=0 -> gnt 3 cycles after req, 4 wrreq, done on word 4.
//  ch0 and ch1 req together, len=2 each, held -> grants alternate ch0,ch1,ch0,ch1; no interleaved words.
//  ch1 len=100, wrusedw=921 (free 103 < 104) -> stays WAIT_SPACE; wrusedw=920 -> gnt next cycle.
//  ch0 len=3 with valid pattern 1,0,0,1,1 -> exactly 3 wrreq, fifo_data order preserved, done on 5th cycle.
//  ch0 len=0 -> len_err=1, done pulse, no wrreq; ch1 pending is then served.
//  Assert reset_ after word 2 of len=8 -> all outputs 0 immediately; after release ch0 preferred again.

Source files
------------

// File: rtl/tx_fifo_wr_arb.sv
// Frame-granular round-robin arbiter for the shared TX data FIFO write port (two host channels).
// Define TXARB_STATS_EN to add the per-channel completed-frame counters ch0_frm_cnt/ch1_frm_cnt.
module tx_fifo_wr_arb #(
   parameter int unsigned WIDTH    = 256,
   parameter int unsigned DEPTH    = 1024,
   parameter int unsigned PTR      = 10,
   parameter int unsigned LEN_W    = 8,
   parameter int unsigned HEADROOM = 4
) (
   input  logic             clk,
   input  logic             reset_,
   input  logic             ch0_req,
   input  logic [LEN_W-1:0] ch0_len,
   input  logic             ch0_valid,
   input  logic [WIDTH-1:0] ch0_data,
   output logic             ch0_gnt,
   output logic             ch0_done,
   input  logic             ch1_req,
   input  logic [LEN_W-1:0] ch1_len,
   input  logic             ch1_valid,
   input  logic [WIDTH-1:0] ch1_data,
   output logic             ch1_gnt,
   output logic             ch1_done,
   input  logic [PTR:0]     fifo_wrusedw,
   input  logic             fifo_wrfull,
   output logic             fifo_wrreq,
   output logic [WIDTH-1:0] fifo_data,
   output logic             busy,
   output logic             len_err,
   output logic             ovf_err
`ifdef TXARB_STATS_EN
   ,
   output logic [31:0]      ch0_frm_cnt,
   output logic [31:0]      ch1_frm_cnt
`endif
);

   localparam int unsigned UW = PTR + 1;

   typedef enum logic [1:0] {IDLE, SEL, WAIT_SPACE, XFER} state_e;

   state_e             state_q, state_d;
   logic               rr_last_q, rr_last_d;
   logic               win_q, win_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic               gnt0_q, gnt0_d;
   logic               gnt1_q, gnt1_d;
   logic               wrreq_q, wrreq_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic               len_err_q, len_err_d;
   logic               ovf_err_q, ovf_err_d;
   logic               done_c;
   logic               accept_c;
   logic [UW-1:0]      free_c;
   logic [UW-1:0]      need_c;

   // State and datapath registers; reset abandons any frame in flight.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_q   <= IDLE;
         rr_last_q <= 1'b1;
         win_q     <= 1'b0;
         len_q     <= '0;
         cnt_q     <= '0;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         wrreq_q   <= 1'b0;
         data_q    <= '0;
         len_err_q <= 1'b0;
         ovf_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_last_q <= rr_last_d;
         win_q     <= win_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         gnt0_q    <= gnt0_d;
         gnt1_q    <= gnt1_d;
         wrreq_q   <= wrreq_d;
         data_q    <= data_d;
         len_err_q <= len_err_d;
         ovf_err_q <= ovf_err_d;
      end
   end

   // Next-state, admission check and word accounting.
   always_comb begin
      state_d   = state_q;
      rr_last_d = rr_last_q;
      win_d     = win_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      gnt0_d    = gnt0_q;
      gnt1_d    = gnt1_q;
      data_d    = data_q;
      len_err_d = len_err_q;
      done_c    = 1'b0;

      accept_c  = (gnt0_q & ch0_valid) | (gnt1_q & ch1_valid);
      free_c    = UW'(DEPTH) - fifo_wrusedw;
      need_c    = UW'(len_q) + UW'(HEADROOM);
      wrreq_d   = accept_c;
      if (accept_c) begin
         data_d = gnt1_q ? ch1_data : ch0_data;
      end
      // The FIFO samples the registered request together with its current full flag.
      ovf_err_d = ovf_err_q | (wrreq_q & fifo_wrfull);

      case (state_q)
         IDLE: begin
            if (ch0_req | ch1_req) begin
               state_d = SEL;
            end
         end
         SEL: begin
            if (ch0_req & ch1_req) begin
               win_d = ~rr_last_q;
            end else begin
               win_d = ch1_req;
            end
            len_d   = win_d ? ch1_len : ch0_len;
            cnt_d   = '0;
            state_d = (ch0_req | ch1_req) ? WAIT_SPACE : IDLE;
         end
         WAIT_SPACE: begin
            if (len_q == '0) begin
               len_err_d = 1'b1;
               done_c    = 1'b1;
               rr_last_d = win_q;
               state_d   = IDLE;
            end else if (free_c >= need_c) begin
               gnt0_d  = ~win_q;
               gnt1_d  = win_q;
               state_d = XFER;
            end
         end
         XFER: begin
            if (accept_c) begin
               cnt_d = cnt_q + LEN_W'(1);
               if (cnt_q == len_q - LEN_W'(1)) begin
                  done_c    = 1'b1;
                  gnt0_d    = 1'b0;
                  gnt1_d    = 1'b0;
                  rr_last_d = win_q;
                  cnt_d     = '0;
                  state_d   = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign ch0_gnt    = gnt0_q;
   assign ch1_gnt    = gnt1_q;
   assign ch0_done   = done_c & ~win_q;
   assign ch1_done   = done_c & win_q;
   assign fifo_wrreq = wrreq_q;
   assign fifo_data  = data_q;
   assign busy       = (state_q != IDLE);
   assign len_err    = len_err_q;
   assign ovf_err    = ovf_err_q;

`ifdef TXARB_STATS_EN
   logic [31:0] frm0_q;
   logic [31:0] frm1_q;

   // Completed-frame counters, zero-length frames included; wrap naturally.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         frm0_q <= '0;
         frm1_q <= '0;
      end else begin
         if (ch0_done) frm0_q <= frm0_q + 32'd1;
         if (ch1_done) frm1_q <= frm1_q + 32'd1;
      end
   end

   assign ch0_frm_cnt = frm0_q;
   assign ch1_frm_cnt = frm1_q;
`endif

endmodule

// File: tb/tb_tx_fifo_wr_arb.sv
// Self-checking bench for tx_fifo_wr_arb: frame-level reference model, host queues, directed and random phases.
module tb_tx_fifo_wr_arb;
   localparam int unsigned WIDTH = 256;
   localparam int unsigned PTR   = 10;
   localparam int unsigned LEN_W = 8;

   logic             clk;
   logic             reset_;
   logic             ch0_req, ch1_req, ch0_valid, ch1_valid;
   logic [LEN_W-1:0] ch0_len, ch1_len;
   logic [WIDTH-1:0] ch0_data, ch1_data;
   logic             ch0_gnt, ch1_gnt, ch0_done, ch1_done;
   logic [PTR:0]     fifo_wrusedw;
   logic             fifo_wrfull, fifo_wrreq, busy, len_err, ovf_err;
   logic [WIDTH-1:0] fifo_data;
`ifdef TXARB_STATS_EN
   logic [31:0]      ch0_frm_cnt, ch1_frm_cnt;
`endif

   tx_fifo_wr_arb dut (
      .clk(clk), .reset_(reset_),
      .ch0_req(ch0_req), .ch0_len(ch0_len), .ch0_valid(ch0_valid), .ch0_data(ch0_data),
      .ch0_gnt(ch0_gnt), .ch0_done(ch0_done),
      .ch1_req(ch1_req), .ch1_len(ch1_len), .ch1_valid(ch1_valid), .ch1_data(ch1_data),
      .ch1_gnt(ch1_gnt), .ch1_done(ch1_done),
      .fifo_wrusedw(fifo_wrusedw), .fifo_wrfull(fifo_wrfull),
      .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data),
      .busy(busy), .len_err(len_err), .ovf_err(ovf_err)
`ifdef TXARB_STATS_EN
      , .ch0_frm_cnt(ch0_frm_cnt), .ch1_frm_cnt(ch1_frm_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   // Host side: pending frame lengths per channel, valid mode (0 random, 1 always, 2 pattern).
   int hq0[$];
   int hq1[$];
   int vmode0, vmode1;
   int pat[5] = '{1, 0, 0, 1, 1};
   int pidx;
   bit rnd_mode;

   // Reference model: frame ownership, progress and sticky flags.
   int m_act, m_own, m_str, m_len, m_sent, m_pref;
   bit m_wr, m_lerr, m_oerr;
   logic [WIDTH-1:0] m_data;
   int m_frm0, m_frm1;

   // Event log observed from the DUT.
   int gnt_rise0, gnt_rise1, done_cyc0, done_cyc1, n_wr, n_done0, n_done1, n_acc0;
   int gnt_log[$];
   logic [WIDTH-1:0] wr_log[$];
   bit prev_g0, prev_g1;

   task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [WIDTH-1:0] rand_word();
      logic [WIDTH-1:0] w;
      for (int i = 0; i < int'(WIDTH / 32); i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   function automatic int rand_len();
      return ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 24));
   endfunction

   task automatic model_reset();
      m_act = 0; m_own = -1; m_str = 0; m_len = 0; m_sent = 0; m_pref = 0;
      m_wr = 1'b0; m_lerr = 1'b0; m_oerr = 1'b0; m_data = '0;
      m_frm0 = 0; m_frm1 = 0;
   endtask

   task automatic clear_stats();
      gnt_rise0 = -1; gnt_rise1 = -1; done_cyc0 = -1; done_cyc1 = -1;
      n_wr = 0; n_done0 = 0; n_done1 = 0; n_acc0 = 0; pidx = 0;
      gnt_log.delete();
      wr_log.delete();
   endtask

   task automatic drive();
      logic [WIDTH-1:0] w;
      if (rnd_mode) begin
         if (hq0.size() == 0 && $urandom_range(0, 7) == 0) hq0.push_back(rand_len());
         if (hq1.size() == 0 && $urandom_range(0, 7) == 0) hq1.push_back(rand_len());
         fifo_wrusedw = ($urandom_range(0, 7) == 0) ? (PTR+1)'($urandom_range(990, 1024))
                                                   : (PTR+1)'($urandom_range(0, 1000));
         fifo_wrfull  = ($urandom_range(0, 31) == 0);
      end
      ch0_req = (hq0.size() > 0);
      ch1_req = (hq1.size() > 0);
      ch0_len = (hq0.size() > 0) ? LEN_W'(hq0[0]) : LEN_W'($urandom_range(0, 255));
      ch1_len = (hq1.size() > 0) ? LEN_W'(hq1[0]) : LEN_W'($urandom_range(0, 255));
      case (vmode0)
         1:       ch0_valid = 1'b1;
         2:       ch0_valid = (ch0_gnt && pidx < 5) ? (pat[pidx] != 0) : 1'b0;
         default: ch0_valid = ($urandom_range(0, 1) == 1);
      endcase
      ch1_valid = (vmode1 == 1) ? 1'b1 : ($urandom_range(0, 1) == 1);
      w = rand_word(); w[31:0] = 32'(cyc); ch0_data = w;
      w = rand_word(); w[31:0] = 32'(cyc); ch1_data = w;
   endtask

   // One cycle: compare DUT against the model, then advance the model with this cycle's inputs.
   task automatic tick();
      bit wait_ph, acc, e_g0, e_g1, e_d0, e_d1;
      logic [WIDTH-1:0] acc_data;
      #1;
      if (!reset_) begin
         model_reset();
         hq0.delete();
         hq1.delete();
      end
      wait_ph  = (m_act != 0) && (m_own >= 0) && (m_str == 0);
      acc      = (m_str != 0) && ((m_own == 1) ? ch1_valid : ch0_valid);
      acc_data = (m_own == 1) ? ch1_data : ch0_data;
      e_g0 = (m_str != 0) && (m_own == 0);
      e_g1 = (m_str != 0) && (m_own == 1);
      e_d0 = (m_own == 0) && ((wait_ph && m_len == 0) || (acc && m_sent + 1 == m_len));
      e_d1 = (m_own == 1) && ((wait_ph && m_len == 0) || (acc && m_sent + 1 == m_len));

      chk("ch0_gnt", ch0_gnt, e_g0);
      chk("ch1_gnt", ch1_gnt, e_g1);
      chk("ch0_done", ch0_done, e_d0);
      chk("ch1_done", ch1_done, e_d1);
      chk("busy", busy, m_act != 0);
      chk("fifo_wrreq", fifo_wrreq, m_wr);
      if (m_wr) chk("fifo_data", fifo_data, m_data);
      chk("len_err", len_err, m_lerr);
      chk("ovf_err", ovf_err, m_oerr);
`ifdef TXARB_STATS_EN
      chk("ch0_frm_cnt", ch0_frm_cnt, 32'(m_frm0));
      chk("ch1_frm_cnt", ch1_frm_cnt, 32'(m_frm1));
`endif

      if (reset_) begin
         if (ch0_gnt && !prev_g0) begin gnt_rise0 = cyc; gnt_log.push_back(0); end
         if (ch1_gnt && !prev_g1) begin gnt_rise1 = cyc; gnt_log.push_back(1); end
         if (fifo_wrreq) begin n_wr++; wr_log.push_back(fifo_data); end
         if (ch0_done) begin n_done0++; done_cyc0 = cyc; end
         if (ch1_done) begin n_done1++; done_cyc1 = cyc; end
         if (ch0_gnt && ch0_valid) n_acc0++;
         if (ch0_gnt) pidx++;
         if (e_d0 && hq0.size() > 0) void'(hq0.pop_front());
         if (e_d1 && hq1.size() > 0) void'(hq1.pop_front());

         m_oerr = m_oerr | (m_wr && fifo_wrfull);
         m_frm0 += int'(e_d0);
         m_frm1 += int'(e_d1);
         m_wr = acc;
         if (acc) m_data = acc_data;
         if (m_act == 0) begin
            if (ch0_req || ch1_req) begin m_act = 1; m_own = -1; end
         end else if (m_own < 0) begin
            if (ch0_req && ch1_req) m_own = m_pref;
            else if (ch0_req)       m_own = 0;
            else if (ch1_req)       m_own = 1;
            else                    m_act = 0;
            if (m_own >= 0) begin
               m_len  = (m_own == 1) ? int'(ch1_len) : int'(ch0_len);
               m_sent = 0;
            end
         end else if (m_str == 0) begin
            if (m_len == 0) begin
               m_lerr = 1'b1; m_pref = 1 - m_own; m_act = 0; m_own = -1;
            end else if (1024 - int'(fifo_wrusedw) >= m_len + 4) begin
               m_str = 1;
            end
         end else if (acc) begin
            m_sent++;
            if (m_sent == m_len) begin
               m_pref = 1 - m_own; m_str = 0; m_act = 0; m_own = -1;
            end
         end
      end
      prev_g0 = ch0_gnt;
      prev_g1 = ch1_gnt;
      cyc++;
      @(negedge clk);
   endtask

   task automatic step();
      drive();
      tick();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_idle(input string name, input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         if (hq0.size() == 0 && hq1.size() == 0 && busy == 1'b0) break;
         step();
      end
      chk({"timeout_", name}, i < budget, 1'b1);
   endtask

   task automatic do_reset();
      reset_ = 1'b0;
      run(2);
      reset_ = 1'b1;
      step();
   endtask

   initial begin
      int r0, i;
      int g;
      reset_ = 1'b0;
      ch0_req = 0; ch1_req = 0; ch0_valid = 0; ch1_valid = 0;
      ch0_len = '0; ch1_len = '0; ch0_data = '0; ch1_data = '0;
      fifo_wrusedw = '0; fifo_wrfull = 1'b0;
      rnd_mode = 0; vmode0 = 1; vmode1 = 0;
      prev_g0 = 0; prev_g1 = 0;
      model_reset();
      clear_stats();
      @(negedge clk);
      run(2);
      reset_ = 1'b1;
      step();
      chk("rst_ch0_gnt", ch0_gnt, 1'b0);
      chk("rst_ch1_gnt", ch1_gnt, 1'b0);
      chk("rst_wrreq", fifo_wrreq, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_errs", {len_err, ovf_err}, 2'b00);

      // Single ch0 frame of 4 words, valid every cycle.
      clear_stats(); vmode0 = 1;
      r0 = cyc;
      hq0.push_back(4);
      wait_idle("t1", 40); run(2);
      chk("t1_gnt_latency", gnt_rise0 - r0, 3);
      chk("t1_done_offset", done_cyc0 - gnt_rise0, 3);
      chk("t1_wrreq_count", n_wr, 4);
      chk("t1_done_count", n_done0, 1);

      // Both channels, two len=2 frames each: grants alternate starting with ch0.
      do_reset();
      clear_stats(); vmode0 = 1; vmode1 = 1;
      hq0.push_back(2); hq0.push_back(2);
      hq1.push_back(2); hq1.push_back(2);
      wait_idle("t2", 80); run(2);
      chk("t2_grant_count", gnt_log.size(), 4);
      for (int k = 0; k < 4; k++) begin
         g = (k < gnt_log.size()) ? gnt_log[k] : -1;
         chk($sformatf("t2_grant_%0d", k), g, k % 2);
      end
      chk("t2_wrreq_count", n_wr, 8);

      // Space threshold: free 103 < 104 holds, free 104 admits.
      clear_stats(); vmode1 = 1;
      fifo_wrusedw = 11'd921;
      hq1.push_back(100);
      run(10);
      chk("t3_hold_busy", busy, 1'b1);
      chk("t3_hold_gnt", ch1_gnt, 1'b0);
      fifo_wrusedw = 11'd920;
      step();
      chk("t3_admit_gnt", ch1_gnt, 1'b1);
      fifo_wrusedw = '0;
      wait_idle("t3", 150); run(2);
      chk("t3_wrreq_count", n_wr, 100);

      // Bubbles: len=3 with valid 1,0,0,1,1.
      clear_stats(); vmode0 = 2;
      hq0.push_back(3);
      wait_idle("t4", 40); run(2);
      chk("t4_wrreq_count", n_wr, 3);
      chk("t4_done_offset", done_cyc0 - gnt_rise0, 4);
      chk("t4_log_size", wr_log.size(), 3);
      if (wr_log.size() == 3) begin
         chk("t4_word0", wr_log[0][31:0], 32'(gnt_rise0));
         chk("t4_word1", wr_log[1][31:0], 32'(gnt_rise0 + 3));
         chk("t4_word2", wr_log[2][31:0], 32'(gnt_rise0 + 4));
      end

      // Zero-length ch0 frame, ch1 pending behind it.
      clear_stats(); vmode0 = 1; vmode1 = 1;
      hq0.push_back(0);
      run(2);
      hq1.push_back(3);
      wait_idle("t5", 40); run(2);
      chk("t5_len_err", len_err, 1'b1);
      chk("t5_done0", n_done0, 1);
      chk("t5_done1", n_done1, 1);
      chk("t5_wrreq_count", n_wr, 3);
      chk("t5_grant_count", gnt_log.size(), 1);

      // Reset after the second word of an 8-word frame.
      clear_stats(); vmode0 = 1;
      hq0.push_back(8);
      for (i = 0; i < 30; i++) begin
         if (n_acc0 >= 2) break;
         step();
      end
      chk("timeout_t6", i < 30, 1'b1);
      reset_ = 1'b0;
      #1;
      chk("t6_rst_gnt", ch0_gnt, 1'b0);
      chk("t6_rst_busy", busy, 1'b0);
      chk("t6_rst_wrreq", fifo_wrreq, 1'b0);
      chk("t6_rst_done", ch0_done, 1'b0);
      chk("t6_rst_len_err", len_err, 1'b0);
      tick();
      step();
      reset_ = 1'b1;
      clear_stats(); vmode0 = 1; vmode1 = 1;
      hq0.push_back(2); hq1.push_back(2);
      wait_idle("t6", 40); run(2);
      g = (gnt_log.size() > 0) ? gnt_log[0] : -1;
      chk("t6_first_grant", g, 0);
      chk("t6_done0", n_done0, 1);
      chk("t6_wrreq_count", n_wr, 4);

      // Random traffic: lengths, bubbles, occupancy near the threshold, occasional full.
      clear_stats(); vmode0 = 0; vmode1 = 0; rnd_mode = 1;
      run(3000);
      rnd_mode = 0; fifo_wrusedw = '0; fifo_wrfull = 1'b0;
      wait_idle("rnd", 400); run(2);
      chk("rnd_progress", (n_done0 + n_done1) > 20, 1'b1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end
endmodule
